// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit:
// FSM state enum, opcode constants, datapath select encodings, ALUOp
// encoding, the per-state control bundle and helper decode functions.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Registered control bundle. 'fetch' marks the FETCH step, where the
    // IR and PC writes are qualified by memReady outside the register.
    typedef struct packed {
        logic       fetch;
        logic       pcupdate;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        aluop_t     aluop;
        logic       illegal;
    } ctrl_t;

    // Moore control values for each state.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c           = '0;
        c.aluop     = ALUOP_ADD;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_B;
        c.resultsrc = RES_ALUOUT;
        case (s)
            FETCH: begin
                c.fetch     = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca = SRCA_OLDPC;
                c.alusrcb = SRCB_IMM;
            end
            MEMADR: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_IMM;
            end
            MEMREAD: c.adrsrc = 1'b1;
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECR: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_FUNCT;
            end
            ALUWB: c.regwrite = 1'b1;
            BEQ: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_SUB;
                c.branch  = 1'b1;
            end
            JAL: begin
                c.alusrca  = SRCA_OLDPC;
                c.alusrcb  = SRCB_FOUR;
                c.pcupdate = 1'b1;
            end
            ERROR: c.illegal = 1'b1;
            default: c.fetch = 1'b1;
        endcase
        return c;
    endfunction

    // Immediate format is a pure function of the opcode.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] r;
        case (op)
            OP_SW:   r = IMM_S;
            OP_BEQ:  r = IMM_B;
            OP_JAL:  r = IMM_J;
            default: r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU control decode: maps ALUOp plus funct3/funct7b5/op[5] to the
// 3-bit ALUControl code. Purely combinational.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    // funct3 000 is sub only for R-type (op[5]=1) with funct7b5 set;
    // addi never subtracts regardless of IR[30].
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the RV32I multicycle core. One state per cycle,
// Moore outputs registered alongside the state; IRWrite/PCWrite are
// qualified combinationally by memReady and zero. Memory stalls hold
// FETCH, MEMREAD and MEMWRITE while memReady is low.
// Optional build macro: MULTICYCLE_PERF_EN adds cycleCount/instrCount.
module multicycle_control
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       memReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output state_t     state_dbg
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] cycleCount,
    output logic [31:0] instrCount
`endif
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;

    // Next-state sequencing, including opcode dispatch from DECODE.
    always_comb begin
        next_state = state;
        case (state)
            FETCH:    next_state = memReady ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECR;
                    OP_ITYPE:     next_state = EXECI;
                    OP_BEQ:       next_state = BEQ;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = ERROR;
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = memReady ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = memReady ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
            ERROR:    next_state = ERROR;
            default:  next_state = FETCH;
        endcase
    end

    // State register with the control bundle registered for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= next_state;
            ctrl  <= state_ctrl(next_state);
        end
    end

    // Write enables are masked by reset so nothing commits while it is low,
    // even though the control register sits at its FETCH values.
    assign IRWrite  = reset & ctrl.fetch & memReady;
    assign PCWrite  = reset & ((ctrl.fetch & memReady) | ctrl.pcupdate | (ctrl.branch & zero));
    assign MemWrite = reset & ctrl.memwrite;
    assign RegWrite = reset & ctrl.regwrite;

    assign AdrSrc    = ctrl.adrsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ResultSrc = ctrl.resultsrc;
    assign illegal   = ctrl.illegal;
    assign ImmSrc    = imm_src(op);
    assign state_dbg = state;

    alu_decoder u_alu_decoder (
        .aluop      (ctrl.aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

`ifdef MULTICYCLE_PERF_EN
    // Cycle and retired-instruction counters; both hold once in ERROR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleCount <= 32'd0;
            instrCount <= 32'd0;
        end else if (state != ERROR) begin
            cycleCount <= cycleCount + 32'd1;
            if (next_state == FETCH &&
                (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ))
                instrCount <= instrCount + 32'd1;
        end
    end
`endif

endmodule
